fp_align_unpack: RTL and testbench
==================================

Name: fp_align_unpack

Overview:
- Front end of the floating-point add/sub datapath.
- Accepts two packed IEEE-style operands and unpacks them, inserting the hidden bit and handling denormals.
- Orders the operands by magnitude, then right-aligns the smaller mantissa, shifting one bit per cycle with sticky accumulation.
- Output format is the `{hidden, fraction, guard, round}` + loss form consumed by the round stage; valid/ready handshake on both sides.

Parameters:
- EXP_SIZE, 8: exponent field width.
- MANTIS_SIZE, 23: stored fraction width, hidden bit excluded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- a  in  EXP_SIZE+MANTIS_SIZE+1  operand A, packed as {sign, exp, frac}.
- b  in  EXP_SIZE+MANTIS_SIZE+1  operand B, same packing.
- operator  in  1  0 = add, 1 = sub (A−B).
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- exp_out  out  EXP_SIZE  common exponent (exponent of the larger operand).
- mantis_big  out  MANTIS_SIZE+3  larger mantissa as {hidden, frac, 2'b00}.
- mantis_small  out  MANTIS_SIZE+3  aligned smaller mantissa as {hidden, frac, g, r}.
- loss  out  1  OR of every bit shifted past the r position (sticky).
- sign_out  out  1  sign of the larger operand, after the subtract adjustment.
- op_eff  out  1  effective operation: operator ^ sign_a ^ sign_b.

Behaviour:
- Reset: state IDLE. out_valid, exp_out, mantis_big, mantis_small, loss, sign_out and op_eff are all 0. in_ready = 1 (in_ready is 1 exactly when state is IDLE).
- A reset asserted in any state, including mid-SHIFT or DONE, abandons the operation and returns to reset values on the next edge.
- Unpack:
  - hidden = |exp.
  - Effective exponent = exp if exp != 0, otherwise 1 (denormal).
  - Mantissa = {hidden, frac, 2'b00}.
- Order:
  - swapped = (eexp_b > eexp_a) or (eexp_b == eexp_a and mant_b > mant_a).
  - Big operand = swapped ? B : A. Equal magnitudes → no swap.
  - sign_out = swapped ? (sign_b ^ operator) : sign_a.
- diff = eexp_big − eexp_small, EXP_SIZE bits, never negative.
- IDLE: on in_valid & in_ready, register the unpacked/ordered operands and clear loss. Next state:
  - diff == 0 → DONE.
  - diff > MANTIS_SIZE+2 → DONE, with mantis_small = 0 and loss = |mant_small (single-cycle flush).
  - otherwise → SHIFT, with cnt = diff.
- SHIFT, each cycle:
  - mantis_small <= mantis_small >> 1.
  - loss <= loss | mantis_small[0].
  - cnt <= cnt − 1.
  - Go to DONE when cnt == 1, or early when mantis_small == 0 (loss is then already final).
- DONE:
  - out_valid = 1; all outputs held stable while out_ready = 0.
  - On out_ready, go to IDLE with out_valid = 0.
  - in_valid is ignored outside IDLE.
- Latency, from the accept edge to out_valid = 1:
  - 1 cycle when diff == 0, diff > MANTIS_SIZE+2, or the small mantissa is 0.
  - Otherwise 1 + (number of shifts), at most MANTIS_SIZE+3 cycles.
- Throughput: one pair per (latency + 1) cycles minimum; no back-to-back acceptance.
- Zero operands are plain denormals with frac 0; no special handling.
- Inf/NaN are passed through unaligned-safe (exp all ones treated numerically); the downstream stage owns special-value handling.

Test Plan:
- a=0x3FC00000, b=0x3F800000, add → out_valid 1 cycle after accept; exp_out=0x7F, mantis_big=0x3000000, mantis_small=0x2000000, loss=0, sign_out=0, op_eff=0.
- a=0x3F800000, b=0x3E000001 (diff 3), add → out_valid 4 cycles after accept; mantis_small=0x0400000, loss=1 (bit pattern 100 shifted out).
- a=0x3E800000, b=0x3F800000, sub → swapped; exp_out=0x7F, mantis_big=0x2000000, mantis_small=0x0800000, sign_out=1, op_eff=1.
- a=0x4D800000, b=0x3F800000 (diff 28) → single-cycle flush; mantis_small=0, loss=1, exp_out=0x9B.
- diff-2 case with out_ready held low 5 cycles → outputs and out_valid stable, in_ready=0; out_ready pulse → out_valid=0 and in_ready=1 on the next cycle.
- rst asserted on the 2nd SHIFT cycle of a diff-10 case → next cycle state IDLE, all outputs 0, in_ready=1; a following pair is processed correctly.

Source files
------------

// File: rtl/fp_align_unpack.sv
// fp_align_unpack
//   Front end of the floating-point add/sub datapath. It unpacks two packed
//   operands {sign, exp, frac}, inserts the hidden bit (with denormals using
//   an effective exponent of 1), and orders them by magnitude. It then
//   right-aligns the smaller mantissa one bit per cycle while accumulating a
//   sticky loss bit.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready    operand pair handshake (ready only while idle)
//   a, b          packed operands {sign, exp[EXP_SIZE], frac[MANTIS_SIZE]}
//   operator      0 = add, 1 = sub (A - B)
//   out_valid/out_ready  result handshake; outputs hold while stalled
//   exp_out       common exponent (exponent of the larger operand)
//   mantis_big    {hidden, frac, 2'b00} of the larger operand
//   mantis_small  aligned {hidden, frac, g, r} of the smaller operand
//   loss          sticky OR of bits shifted past the r position
//   sign_out      sign of the larger operand after subtract adjustment
//   op_eff        effective operation: operator ^ sign_a ^ sign_b
module fp_align_unpack #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     a,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]     b,
  input  logic                              operator,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_SIZE-1:0]               exp_out,
  output logic [MANTIS_SIZE+2:0]            mantis_big,
  output logic [MANTIS_SIZE+2:0]            mantis_small,
  output logic                              loss,
  output logic                              sign_out,
  output logic                              op_eff
);

  localparam int W  = EXP_SIZE + MANTIS_SIZE + 1;
  localparam int MW = MANTIS_SIZE + 3;
  localparam logic [EXP_SIZE-1:0] ONE       = EXP_SIZE'(1);
  localparam logic [EXP_SIZE-1:0] MAX_SHIFT = EXP_SIZE'(MANTIS_SIZE + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [EXP_SIZE-1:0] cnt;

  logic                sign_a, sign_b;
  logic [EXP_SIZE-1:0] exp_a, exp_b;
  logic [EXP_SIZE-1:0] eexp_a, eexp_b;
  logic [MW-1:0]       mant_a, mant_b;
  logic                swapped;
  logic [EXP_SIZE-1:0] eexp_big, eexp_small, diff;
  logic [MW-1:0]       mant_big_c, mant_small_c;
  logic                sign_big;

  // Unpack and magnitude ordering of the incoming pair.
  always_comb begin
    sign_a = a[W-1];
    sign_b = b[W-1];
    exp_a  = a[W-2:MANTIS_SIZE];
    exp_b  = b[W-2:MANTIS_SIZE];
    eexp_a = (exp_a != '0) ? exp_a : ONE;
    eexp_b = (exp_b != '0) ? exp_b : ONE;
    mant_a = {(|exp_a), a[MANTIS_SIZE-1:0], 2'b00};
    mant_b = {(|exp_b), b[MANTIS_SIZE-1:0], 2'b00};

    swapped = (eexp_b > eexp_a) || ((eexp_b == eexp_a) && (mant_b > mant_a));

    eexp_big     = swapped ? eexp_b : eexp_a;
    eexp_small   = swapped ? eexp_a : eexp_b;
    mant_big_c   = swapped ? mant_b : mant_a;
    mant_small_c = swapped ? mant_a : mant_b;
    sign_big     = swapped ? (sign_b ^ operator) : sign_a;
    diff         = eexp_big - eexp_small;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid    <= 1'b0;
      exp_out      <= '0;
      mantis_big   <= '0;
      mantis_small <= '0;
      loss         <= 1'b0;
      sign_out     <= 1'b0;
      op_eff       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            exp_out    <= eexp_big;
            mantis_big <= mant_big_c;
            sign_out   <= sign_big;
            op_eff     <= operator ^ sign_a ^ sign_b;
            loss       <= 1'b0;
            cnt        <= diff;
            if (diff > MAX_SHIFT) begin
              // Everything falls past r: flush in one step.
              mantis_small <= '0;
              loss         <= |mant_small_c;
              out_valid    <= 1'b1;
              state        <= DONE;
            end else if ((diff == '0) || (mant_small_c == '0)) begin
              mantis_small <= mant_small_c;
              out_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              mantis_small <= mant_small_c;
              state        <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mantis_small <= mantis_small >> 1;
          loss         <= loss | mantis_small[0];
          cnt          <= cnt - ONE;
          // Stop early once the shifted value is zero: no bits left to lose.
          if ((cnt == ONE) || (mantis_small[MW-1:1] == '0)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_unpack.sv
// Self-checking bench for fp_align_unpack: directed cases plus randomized
// operand pairs compared against an arithmetic reference model.
module tb_fp_align_unpack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        operator;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [25:0] mantis_big;
  logic [25:0] mantis_small;
  logic        loss;
  logic        sign_out;
  logic        op_eff;

  int unsigned n_tests;
  int unsigned n_fail;

  // Values captured when out_valid is first seen, for directed checks.
  longint obs_lat;
  logic [63:0] obs_exp, obs_big, obs_small, obs_loss, obs_sign, obs_op;

  fp_align_unpack #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operator(operator),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .mantis_big(mantis_big), .mantis_small(mantis_small),
    .loss(loss), .sign_out(sign_out), .op_eff(op_eff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: magnitudes as integers, alignment as a plain division.
  task automatic model(input logic [31:0] xa, input logic [31:0] xb, input logic op,
                       output longint e_exp, output longint e_big, output longint e_small,
                       output longint e_loss, output longint e_sign, output longint e_op,
                       output longint e_lat);
    longint ea, eb, ma, mb, mag_a, mag_b, ms, d, bl;
    bit sw;
    ea = (xa[30:23] != 0) ? longint'(xa[30:23]) : 1;
    eb = (xb[30:23] != 0) ? longint'(xb[30:23]) : 1;
    ma = ((xa[30:23] != 0) ? 64'd33554432 : 64'd0) + longint'(xa[22:0]) * 4;
    mb = ((xb[30:23] != 0) ? 64'd33554432 : 64'd0) + longint'(xb[22:0]) * 4;
    mag_a = ea * 67108864 + ma;
    mag_b = eb * 67108864 + mb;
    sw = (mag_b > mag_a);
    e_exp  = sw ? eb : ea;
    e_big  = sw ? mb : ma;
    ms     = sw ? ma : mb;
    d      = sw ? (eb - ea) : (ea - eb);
    e_sign = sw ? longint'(xb[31] ^ op) : longint'(xa[31]);
    e_op   = longint'(op ^ xa[31] ^ xb[31]);
    if (d > 25) begin
      e_small = 0;
      e_loss  = (ms != 0) ? 1 : 0;
    end else begin
      e_small = ms / (64'd1 << d);
      e_loss  = ((ms % (64'd1 << d)) != 0) ? 1 : 0;
    end
    bl = (ms == 0) ? 0 : longint'($clog2(ms + 1));
    if (d == 0 || ms == 0 || d > 25) e_lat = 1;
    else e_lat = 1 + ((d < bl) ? d : bl);
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic op,
                      input int hold);
    longint e_exp, e_big, e_small, e_loss, e_sign, e_op, e_lat;
    longint lat;
    model(xa, xb, op, e_exp, e_big, e_small, e_loss, e_sign, e_op, e_lat);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    a = xa; b = xb; operator = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("exp_out", 64'(exp_out), 64'(e_exp));
    check("mantis_big", 64'(mantis_big), 64'(e_big));
    check("mantis_small", 64'(mantis_small), 64'(e_small));
    check("loss", 64'(loss), 64'(e_loss));
    check("sign_out", 64'(sign_out), 64'(e_sign));
    check("op_eff", 64'(op_eff), 64'(e_op));
    obs_lat = lat; obs_exp = 64'(exp_out); obs_big = 64'(mantis_big);
    obs_small = 64'(mantis_small); obs_loss = 64'(loss);
    obs_sign = 64'(sign_out); obs_op = 64'(op_eff);
    // Stall with fresh (ignored) input traffic; outputs must not move.
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; operator = 1'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_small", 64'(mantis_small), 64'(e_small));
      check("hold_exp", 64'(exp_out), 64'(e_exp));
      check("hold_big", 64'(mantis_big), 64'(e_big));
      check("hold_loss", 64'(loss), 64'(e_loss));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_ready", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_operand(input int unsigned e);
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0: f = '0;
      1: f = 23'($urandom_range(0, 15));
      default: ;
    endcase
    return {1'($urandom), 8'(e), f};
  endfunction

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; operator = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_exp", 64'(exp_out), 64'd0);
    check("rst_big", 64'(mantis_big), 64'd0);
    check("rst_small", 64'(mantis_small), 64'd0);
    check("rst_flags", 64'({loss, sign_out, op_eff}), 64'd0);
    rst = 1'b0;

    // Equal exponents, no shift.
    send(32'h3FC00000, 32'h3F800000, 1'b0, 0);
    check("t1_lat", 64'(obs_lat), 64'd1);
    check("t1_big", obs_big, 64'h3000000);
    check("t1_small", obs_small, 64'h2000000);
    check("t1_exp", obs_exp, 64'h7F);

    // diff 3 with sticky loss.
    send(32'h3F800000, 32'h3E000001, 1'b0, 0);
    check("t2_lat", 64'(obs_lat), 64'd4);
    check("t2_small", obs_small, 64'h0400000);
    check("t2_loss", obs_loss, 64'd1);

    // Swapped subtract.
    send(32'h3E800000, 32'h3F800000, 1'b1, 0);
    check("t3_big", obs_big, 64'h2000000);
    check("t3_small", obs_small, 64'h0800000);
    check("t3_sign", obs_sign, 64'd1);
    check("t3_op", obs_op, 64'd1);

    // Large diff flush.
    send(32'h4D800000, 32'h3F800000, 1'b0, 0);
    check("t4_lat", 64'(obs_lat), 64'd1);
    check("t4_small", obs_small, 64'd0);
    check("t4_loss", obs_loss, 64'd1);
    check("t4_exp", obs_exp, 64'h9B);

    // Boundary diffs 25 and 26, and a stall of 5 cycles on diff 2.
    send(32'h4C000000, 32'h3F800001, 1'b0, 0);
    send(32'h4C800000, 32'h3F800001, 1'b0, 0);
    send(32'h40800000, 32'h3F800003, 1'b0, 5);
    // Zero small operand and denormal with early exit.
    send(32'h3F800000, 32'h00000000, 1'b1, 1);
    send(32'h0A000000, 32'h00000005, 1'b0, 0);

    // Reset on the second SHIFT cycle of a diff-10 case.
    @(negedge clk);
    a = 32'h44800000; b = 32'h3F800000; operator = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out", 64'({exp_out, mantis_big, mantis_small, loss, sign_out, op_eff}), 64'd0);
    send(32'h40000000, 32'hBF800000, 1'b1, 2);

    // Randomized pairs with nearby exponents.
    for (int unsigned n = 0; n < 60; n++) begin
      int ea, eb;
      ea = int'($urandom_range(0, 255));
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      if ($urandom_range(0, 7) == 0) eb = 0;
      send(rand_operand(ea), rand_operand(eb), 1'($urandom),
           int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
